// File: rtl/mole_light_sequencer_if.sv
// Control/status bundle between a game controller (master) and the mole light sequencer (slave).
interface mole_light_sequencer_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int POS_W      = 4,
  parameter int TIMER_W    = 28,
  parameter int COUNT_W    = 6
);
  logic                  start;
  logic                  load_seed;
  logic [TIMER_W-1:0]    time_between;
  logic [TIMER_W-1:0]    time_on;
  logic [COUNT_W-1:0]    max_flicks;
  logic [NUM_LIGHTS-1:0] hit;
  logic [NUM_LIGHTS-1:0] lights;
  logic [POS_W-1:0]      light_pos;
  logic [COUNT_W-1:0]    flick_count;
  logic [COUNT_W-1:0]    hit_count;
  logic [COUNT_W-1:0]    miss_count;
  logic                  hit_pulse;
  logic                  miss_pulse;
  logic                  busy;
  logic                  done;

  modport master (
    output start, load_seed, time_between, time_on, max_flicks, hit,
    input  lights, light_pos, flick_count, hit_count, miss_count,
           hit_pulse, miss_pulse, busy, done
  );

  modport slave (
    input  start, load_seed, time_between, time_on, max_flicks, hit,
    output lights, light_pos, flick_count, hit_count, miss_count,
           hit_pulse, miss_pulse, busy, done
  );
endinterface

// File: rtl/mole_light_sequencer.sv
// Whack-a-mole sequencer: lights one LFSR-chosen position at a time, paced by off/on countdowns.
// Optional LIGHT_NO_REPEAT_EN: within a round, never light the same position twice in a row.
module mole_light_sequencer #(
  parameter int          NUM_LIGHTS = 9,
  parameter int          POS_W      = 4,
  parameter int          TIMER_W    = 28,
  parameter int          COUNT_W    = 6,
  parameter logic [15:0] SEED       = 16'h0059
) (
  input logic clk,
  input logic reset,
  mole_light_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_BTWN, FLICK, WAIT_ON, DONE} state_t;

  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  state_t                state, state_next;
  logic [15:0]           lfsr;
  logic [TIMER_W-1:0]    countdown;
  logic [NUM_LIGHTS-1:0] lights_q;
  logic [POS_W-1:0]      pos_q;
  logic [POS_W-1:0]      raw_pos, next_pos;
  logic [COUNT_W-1:0]    flick_q, hit_q, miss_q;
  logic                  hit_pulse_q, miss_pulse_q;
  logic                  hit_now, round_over;
  logic clear_counts, load_between, load_on, dec_count, do_flick, do_hit, do_miss;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             lfsr <= 16'h0001;
    else if (bus.load_seed) lfsr <= SEED_EFF;
    else if (lfsr[0])       lfsr <= (lfsr >> 1) ^ LFSR_MASK;
    else                    lfsr <= lfsr >> 1;
  end

  assign raw_pos = POS_W'(lfsr % 16'(NUM_LIGHTS));

`ifdef LIGHT_NO_REPEAT_EN
  logic prev_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            prev_valid <= 1'b0;
    else if (clear_counts) prev_valid <= 1'b0;
    else if (do_flick)     prev_valid <= 1'b1;
  end

  always_comb begin
    next_pos = raw_pos;
    if (prev_valid && (raw_pos == pos_q))
      next_pos = (raw_pos == POS_W'(NUM_LIGHTS - 1)) ? '0 : raw_pos + POS_W'(1);
  end
`else
  assign next_pos = raw_pos;
`endif

  // Only the lit bit can register a hit because lights_q is one-hot at pos_q during WAIT_ON.
  assign hit_now    = |(bus.hit & lights_q);
  assign round_over = (bus.max_flicks != '0) && (flick_q == bus.max_flicks);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    clear_counts = 1'b0;
    load_between = 1'b0;
    load_on      = 1'b0;
    dec_count    = 1'b0;
    do_flick     = 1'b0;
    do_hit       = 1'b0;
    do_miss      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          clear_counts = 1'b1;
          load_between = 1'b1;
          state_next   = WAIT_BTWN;
        end
      end
      WAIT_BTWN: begin
        if (bus.start) begin
          if (countdown == '0) state_next = FLICK;
          else                 dec_count  = 1'b1;
        end
      end
      FLICK: begin
        do_flick   = 1'b1;
        load_on    = 1'b1;
        state_next = WAIT_ON;
      end
      WAIT_ON: begin
        if (bus.start) begin
          if (hit_now)              do_hit    = 1'b1;
          else if (countdown == '0) do_miss   = 1'b1;
          else                      dec_count = 1'b1;
          if (hit_now || (countdown == '0)) begin
            if (round_over) begin
              state_next = DONE;
            end else begin
              load_between = 1'b1;
              state_next   = WAIT_BTWN;
            end
          end
        end
      end
      DONE: begin
        if (!bus.start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      countdown    <= '0;
      lights_q     <= '0;
      pos_q        <= '0;
      flick_q      <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      hit_pulse_q  <= do_hit;
      miss_pulse_q <= do_miss;
      if (load_between)   countdown <= bus.time_between;
      else if (load_on)   countdown <= bus.time_on;
      else if (dec_count) countdown <= countdown - TIMER_W'(1);
      if (clear_counts) begin
        flick_q <= '0;
        hit_q   <= '0;
        miss_q  <= '0;
      end
      if (do_flick) begin
        pos_q    <= next_pos;
        lights_q <= NUM_LIGHTS'(1) << next_pos;
        flick_q  <= sat_inc(flick_q);
      end
      if (do_hit) begin
        hit_q    <= sat_inc(hit_q);
        lights_q <= '0;
      end
      if (do_miss) begin
        miss_q   <= sat_inc(miss_q);
        lights_q <= '0;
      end
    end
  end

  assign bus.lights      = lights_q;
  assign bus.light_pos   = pos_q;
  assign bus.flick_count = flick_q;
  assign bus.hit_count   = hit_q;
  assign bus.miss_count  = miss_q;
  assign bus.hit_pulse   = hit_pulse_q;
  assign bus.miss_pulse  = miss_pulse_q;
  assign bus.busy        = (state != IDLE) && (state != DONE);
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_mole_light_sequencer.sv
// Randomized bench for mole_light_sequencer: a cycle-counting game model predicts every
// hit/miss pulse (timing, position, counters); a monitor pops and compares them.
module tb_mole_light_sequencer;
`ifdef LIGHT_NO_REPEAT_EN
  localparam int NUM_LIGHTS = 2;
  localparam int LONG_FLICKS = 200;
`else
  localparam int NUM_LIGHTS = 9;
  localparam int LONG_FLICKS = 70;
`endif
  localparam int POS_W = 4;
  localparam int TIMER_W = 28;
  localparam int COUNT_W = 6;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;
  localparam logic [15:0] SEED = 16'h0059;

  typedef struct {
    bit          is_hit;
    int          pos;
    int          flicks;
    int          hits;
    int          misses;
    int unsigned at_cycle;
  } pulse_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mole_light_sequencer_if #(.NUM_LIGHTS(NUM_LIGHTS), .POS_W(POS_W), .TIMER_W(TIMER_W),
                            .COUNT_W(COUNT_W)) bus ();

  mole_light_sequencer #(.NUM_LIGHTS(NUM_LIGHTS), .POS_W(POS_W), .TIMER_W(TIMER_W),
                         .COUNT_W(COUNT_W), .SEED(SEED)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  int unsigned cycle = 0;
  int cfg_tb = 0, cfg_to = 0, cfg_max = 0;
  int m_flicks, m_hits, m_misses;
  pulse_t sb[$];
  logic [15:0] model_lfsr;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference LFSR: the position source the game rules are defined on.
  always @(posedge clk or negedge reset) begin
    if (!reset)             model_lfsr <= 16'h0001;
    else if (bus.load_seed) model_lfsr <= (SEED == 16'h0000) ? 16'h0001 : SEED;
    else                    model_lfsr <= model_lfsr[0] ? ((model_lfsr >> 1) ^ 16'hB400)
                                                        : (model_lfsr >> 1);
  end

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic logic [NUM_LIGHTS-1:0] noise();
    return ($urandom_range(0, 2) == 0) ? NUM_LIGHTS'($urandom) : '0;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Timer inputs carry junk except on cycles where the sequencer is supposed to sample them.
  task automatic applyStimulus(input logic st, input logic [NUM_LIGHTS-1:0] h, input bit load_ok);
    @(posedge clk);
    #1;
    bus.start        = st;
    bus.hit          = h;
    bus.load_seed    = 1'b0;
    bus.time_between = load_ok ? TIMER_W'(cfg_tb) : TIMER_W'($urandom);
    bus.time_on      = load_ok ? TIMER_W'(cfg_to) : TIMER_W'($urandom);
    bus.max_flicks   = COUNT_W'(cfg_max);
  endtask

  task automatic runCycle(input logic st, input logic [NUM_LIGHTS-1:0] h, input bit load_ok,
                          input logic [NUM_LIGHTS-1:0] exp_lights, input bit exp_busy,
                          input bit exp_done);
    applyStimulus(st, h, load_ok);
    @(negedge clk);
    checkOutput("lights", longint'(bus.lights), longint'(exp_lights));
    checkOutput("busy", longint'(bus.busy), longint'(exp_busy));
    checkOutput("done", longint'(bus.done), longint'(exp_done));
  endtask

  task automatic seedLfsr();
    applyStimulus(1'b0, '0, 1'b0);
    bus.load_seed = 1'b1;
  endtask

  task automatic playRound(input int tbv, input int tov, input int maxv, input int n_limit,
                           input bit end_reset);
    logic [NUM_LIGHTS-1:0] onehot, h;
    int raw, pos, prev_pos, k, pause_at, pause_len, active, flick_no;
    bit prev_valid, is_hit, decision;
    cfg_tb = tbv; cfg_to = tov; cfg_max = maxv;
    m_flicks = 0; m_hits = 0; m_misses = 0;
    prev_valid = 0; prev_pos = 0; flick_no = 0;
    runCycle(1'b1, noise(), 1'b1, '0, 1'b0, 1'b0);
    forever begin
      repeat (tbv + 1) runCycle(1'b1, noise(), 1'b0, '0, 1'b1, 1'b0);
      runCycle(1'b1, noise(), 1'b1, '0, 1'b1, 1'b0);
      raw = int'(model_lfsr % 16'(NUM_LIGHTS));
      pos = raw;
`ifdef LIGHT_NO_REPEAT_EN
      if (prev_valid && raw == prev_pos) pos = (raw + 1) % NUM_LIGHTS;
`endif
      prev_pos = pos; prev_valid = 1;
      onehot = '0;
      onehot[pos] = 1'b1;
      m_flicks = sat(m_flicks);
      flick_no++;
      if (end_reset && flick_no > n_limit) begin
        runCycle(1'b1, '0, 1'b0, onehot, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        bus.start = 1'b0;
        #1;
        checkOutput("rst_lights", longint'(bus.lights), 0);
        checkOutput("rst_light_pos", longint'(bus.light_pos), 0);
        checkOutput("rst_flick_count", longint'(bus.flick_count), 0);
        checkOutput("rst_hit_count", longint'(bus.hit_count), 0);
        checkOutput("rst_miss_count", longint'(bus.miss_count), 0);
        checkOutput("rst_busy", longint'(bus.busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        return;
      end
      is_hit = bit'($urandom_range(0, 1));
      k = $urandom_range(0, tov);
      pause_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tov) : -1;
      pause_len = $urandom_range(1, 10);
      active = 0;
      forever begin
        if (active == pause_at && pause_len > 0) begin
          runCycle(1'b0, NUM_LIGHTS'($urandom) | onehot, 1'b0, onehot, 1'b1, 1'b0);
          pause_len--;
          continue;
        end
        decision = (is_hit && active == k) || (active == tov);
        h = ($urandom_range(0, 1) == 1) ? (NUM_LIGHTS'($urandom) & ~onehot) : '0;
        if (is_hit && active == k) h = h | onehot;
        runCycle(1'b1, h, decision, onehot, 1'b1, 1'b0);
        if (decision) break;
        active++;
      end
      if (is_hit) m_hits = sat(m_hits);
      else        m_misses = sat(m_misses);
      sb.push_back('{is_hit, pos, m_flicks, m_hits, m_misses, cycle + 1});
      if (maxv != 0 && m_flicks == maxv) begin
        runCycle(1'b1, noise(), 1'b0, '0, 1'b0, 1'b1);
        runCycle(1'b0, noise(), 1'b0, '0, 1'b0, 1'b1);
        runCycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("held_flick_count", longint'(bus.flick_count), m_flicks);
        checkOutput("held_hit_count", longint'(bus.hit_count), m_hits);
        checkOutput("held_miss_count", longint'(bus.miss_count), m_misses);
        return;
      end
    end
  endtask

  // Monitor: every pulse the DUT presents must match the oldest predicted outcome.
  initial begin
    pulse_t e;
    forever begin
      @(negedge clk);
      if (reset && (bus.hit_pulse || bus.miss_pulse)) begin
        if (sb.size() == 0) begin
          checkOutput("pending_outcomes", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          checkOutput("hit_pulse", longint'(bus.hit_pulse), longint'(e.is_hit));
          checkOutput("miss_pulse", longint'(bus.miss_pulse), longint'(!e.is_hit));
          checkOutput("pulse_cycle", longint'(cycle), longint'(e.at_cycle));
          checkOutput("light_pos", longint'(bus.light_pos), e.pos);
          checkOutput("lights_cleared", longint'(bus.lights), 0);
          checkOutput("flick_count", longint'(bus.flick_count), e.flicks);
          checkOutput("hit_count", longint'(bus.hit_count), e.hits);
          checkOutput("miss_count", longint'(bus.miss_count), e.misses);
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.load_seed = 1'b0; bus.hit = '0;
    bus.time_between = '0; bus.time_on = '0; bus.max_flicks = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_lights", longint'(bus.lights), 0);
    checkOutput("reset_light_pos", longint'(bus.light_pos), 0);
    checkOutput("reset_flick_count", longint'(bus.flick_count), 0);
    checkOutput("reset_hit_count", longint'(bus.hit_count), 0);
    checkOutput("reset_miss_count", longint'(bus.miss_count), 0);
    checkOutput("reset_hit_pulse", longint'(bus.hit_pulse), 0);
    checkOutput("reset_miss_pulse", longint'(bus.miss_pulse), 0);
    checkOutput("reset_busy", longint'(bus.busy), 0);
    checkOutput("reset_done", longint'(bus.done), 0);
    reset = 1'b1;
    seedLfsr();
    playRound(3, 5, 3, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) seedLfsr();
      playRound($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(1, 6), 0, 1'b0);
    end
    playRound(0, 1, 0, LONG_FLICKS, 1'b1);
    playRound(0, 0, 3, 0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("outcomes_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mole_light_sequencer.md
Name: mole_light_sequencer

Overview:
Parametrised whack-a-mole light sequencer driving NUM_LIGHTS board lights, one at a time, at pseudo-random positions. Internal LFSR picks the position; programmable between/on timers set the pacing. Player hit inputs end a lit period early. Hit, miss and flick counters feed the score/display logic. The game-round ends after a programmable number of flicks.

Parameters:
NUM_LIGHTS, 9, number of lights; 2..16
POS_W, 4, width of light_pos; 2^POS_W >= NUM_LIGHTS
TIMER_W, 28, width of time_on/time_between and internal countdowns
COUNT_W, 6, width of flick/hit/miss counters
SEED, 16'h0059, LFSR load value; a zero value loads 16'h0001 instead

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  run enable; low pauses timers, high in IDLE begins a round
load_seed  in  1  synchronous; loads SEED into the LFSR
time_between  in  TIMER_W  off-period length, sampled on load
time_on  in  TIMER_W  on-period length, sampled on load
max_flicks  in  COUNT_W  flicks per round; 0 = unlimited
hit  in  NUM_LIGHTS  debounced, synchronous player button pulses
lights  out  NUM_LIGHTS  registered one-hot light drive, or all zero
light_pos  out  POS_W  position of the current/last lit light
flick_count  out  COUNT_W  flicks this round
hit_count  out  COUNT_W  successful hits this round
miss_count  out  COUNT_W  timeouts this round
hit_pulse  out  1  one-cycle pulse after a hit
miss_pulse  out  1  one-cycle pulse after a miss
busy  out  1  high in any state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset is async, active-low: all outputs 0, state IDLE, LFSR = 16'h0001, countdown = 0.
- LFSR: 16-bit Galois, mask 16'hB400, advances every cycle. load_seed has priority over advancing.
- Raw position = LFSR mod NUM_LIGHTS.
- States: IDLE, WAIT_BTWN, FLICK, WAIT_ON, DONE.
- IDLE, start=1: clear the three counters, load countdown with time_between, go to WAIT_BTWN.
- WAIT_BTWN:
  - start=0: countdown holds.
  - Countdown != 0: decrement.
  - Countdown == 0: go to FLICK.
  - Duration is time_between+1 cycles with start held.
- FLICK, one cycle:
  - Register position into light_pos.
  - Set the matching lights bit.
  - Increment flick_count.
  - Load countdown with time_on, go to WAIT_ON.
  - Lights are visible from the first WAIT_ON cycle.
- WAIT_ON, evaluated only while start=1:
  - hit[light_pos]=1: hit_count++, hit_pulse next cycle, lights cleared, exit.
  - Else countdown == 0: miss_count++, miss_pulse next cycle, lights cleared, exit.
  - Else decrement.
- Exit from WAIT_ON:
  - max_flicks != 0 and flick_count == max_flicks: go to DONE.
  - Otherwise load time_between and go to WAIT_BTWN.
- Hit and timeout in the same cycle: counts as a hit only.
- Hits on unlit positions, or outside WAIT_ON, are ignored.
- hit while start=0: ignored.
- DONE: lights=0, done=1. start=0 returns to IDLE; counters are held until the next round.
- Counters saturate at all-ones; no wrap.
- time_between=0 or time_on=0: state lasts exactly one cycle.
- Input changes mid-period have no effect until the next load.

Optional Feature:
- Macro: LIGHT_NO_REPEAT_EN.
- Defined: if the raw position equals the previous flick's position in the same round, use (raw+1) mod NUM_LIGHTS. The first flick after IDLE is never adjusted; a prev-valid flag is cleared on IDLE exit and on reset.
- Undefined: the raw position is always used; consecutive repeats are allowed.

Test Plan:
- Timing (defaults; time_between=3, time_on=5, max_flicks=0): reset, then start=1 at cycle 0 -> WAIT_BTWN cycles 1-4, FLICK cycle 5. lights one-hot with bit == light_pos in cycles 6-11. lights=0 and miss_pulse=1 in cycle 12. miss_count=1, flick_count=1.
- Hit: same setup, hit[light_pos] pulsed in cycle 8 -> lights=0 and hit_pulse=1 in cycle 9. hit_count=1, miss_count=0. Next FLICK at cycle 13.
- Wrong hit and tie: hit on a non-lit bit -> ignored, timeout miss. Hit pulsed in the cycle countdown==0 -> counted as a hit, miss_count unchanged.
- Pause: start=0 for 10 cycles mid-WAIT_ON -> lights held, countdown frozen. On-period extends to exactly 16 cycles.
- Round end (max_flicks=3, time_between=0, time_on=0, no hits) -> done=1 after the third miss. flick_count=3, miss_count=3. start=0 -> IDLE, busy=0.
- LIGHT_NO_REPEAT_EN, NUM_LIGHTS=2, 200 flicks -> no two consecutive equal light_pos values. Async reset mid-WAIT_ON -> lights, counters and light_pos all 0 immediately.
